// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one data-memory port between the core and a DMA/debug port.
// Core has fixed priority; an anti-starvation counter forces a DMA grant after
// STARVE_LIMIT denied cycles. Read data returns one cycle after a granted read.
// Define DMEM_ARB_PERF_EN to add saturating grant/conflict performance counters.
module dmem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_stall,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]       core_gnt_cnt,
    output logic [31:0]       dma_gnt_cnt,
    output logic [31:0]       conflict_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, RD_CORE, RD_DMA} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t            state, state_nxt;
    logic [3:0]        starve_cnt, starve_nxt;
    logic [DATA_W-1:0] rdata_q;
    logic              c_req, d_req;

    // requests are ignored while reset is held so nothing is granted or written
    assign c_req = core_req & rst;
    assign d_req = dma_req & rst;

    assign core_rvalid = (state == RD_CORE);
    assign dma_rvalid  = (state == RD_DMA);
    assign core_rdata  = rdata_q;
    assign dma_rdata   = rdata_q;

    // arbitration, memory mux, starvation counter and read-return next state
    always_comb begin
        dma_gnt    = d_req & (~c_req | (starve_cnt == LIMIT));
        core_gnt   = c_req & ~dma_gnt;
        core_stall = c_req & ~core_gnt;
        mem_addr   = dma_gnt ? dma_addr  : core_gnt ? core_addr  : '0;
        mem_wdata  = dma_gnt ? dma_wdata : core_gnt ? core_wdata : '0;
        mem_we     = dma_gnt ? dma_we    : core_gnt ? core_we    : 1'b0;
        starve_nxt = (d_req & ~dma_gnt) ? ((starve_cnt == LIMIT) ? starve_cnt : starve_cnt + 4'd1) : 4'd0;
        state_nxt  = (core_gnt & ~core_we) ? RD_CORE : (dma_gnt & ~dma_we) ? RD_DMA : IDLE;
    end

    // state register; a granted read captures the combinational memory data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            starve_cnt <= 4'd0;
            rdata_q    <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            if (state_nxt != IDLE) rdata_q <= mem_rdata;
        end
    end

`ifdef DMEM_ARB_PERF_EN
    // saturating grant and contention counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            core_gnt_cnt <= '0;
            dma_gnt_cnt  <= '0;
            conflict_cnt <= '0;
        end else begin
            if (core_gnt && core_gnt_cnt != '1) core_gnt_cnt <= core_gnt_cnt + 32'd1;
            if (dma_gnt && dma_gnt_cnt != '1) dma_gnt_cnt <= dma_gnt_cnt + 32'd1;
            if (c_req && d_req && conflict_cnt != '1) conflict_cnt <= conflict_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed vector bench for dmem_port_arbiter (STARVE_LIMIT = 4).
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req, core_we, dma_req, dma_we;
    logic [31:0] core_addr, core_wdata, dma_addr, dma_wdata;
    logic        core_gnt, core_stall, core_rvalid, dma_gnt, dma_rvalid, mem_we;
    logic [31:0] core_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0] core_gnt_cnt, dma_gnt_cnt, conflict_cnt;
    logic [31:0] s_c, s_d, s_x;
`endif

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] mem [64];

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;

    dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_stall(core_stall), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_PERF_EN
        , .core_gnt_cnt(core_gnt_cnt), .dma_gnt_cnt(dma_gnt_cnt), .conflict_cnt(conflict_cnt)
`endif
    );

    typedef struct {
        logic        cr, cw;
        logic [31:0] ca, cd;
        logic        dr, dw;
        logic [31:0] da, dd;
        logic        e_cg, e_dg, e_st, e_crv, e_drv, e_we;
        logic [31:0] e_rd, e_ma, e_md;
    } vec_t;

    vec_t v [29];

    function automatic vec_t mk(logic cr, logic cw, logic [31:0] ca, logic [31:0] cd,
                                logic dr, logic dw, logic [31:0] da, logic [31:0] dd,
                                logic e_cg, logic e_dg, logic e_st, logic e_crv, logic e_drv,
                                logic [31:0] e_rd, logic e_we, logic [31:0] e_ma, logic [31:0] e_md);
        vec_t r;
        r.cr = cr; r.cw = cw; r.ca = ca; r.cd = cd;
        r.dr = dr; r.dw = dw; r.da = da; r.dd = dd;
        r.e_cg = e_cg; r.e_dg = e_dg; r.e_st = e_st; r.e_crv = e_crv; r.e_drv = e_drv;
        r.e_rd = e_rd; r.e_we = e_we; r.e_ma = e_ma; r.e_md = e_md;
        return r;
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        core_req = x.cr; core_we = x.cw; core_addr = x.ca; core_wdata = x.cd;
        dma_req = x.dr; dma_we = x.dw; dma_addr = x.da; dma_wdata = x.dd;
    endtask

    task automatic chk_zero(input int row);
        chk("core_gnt", row, 32'(core_gnt), 0);
        chk("dma_gnt", row, 32'(dma_gnt), 0);
        chk("core_stall", row, 32'(core_stall), 0);
        chk("core_rvalid", row, 32'(core_rvalid), 0);
        chk("dma_rvalid", row, 32'(dma_rvalid), 0);
        chk("mem_we", row, 32'(mem_we), 0);
        chk("core_rdata", row, core_rdata, 0);
        chk("mem_addr", row, mem_addr, 0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[0] = 32'hA0A0A0A0;
        mem[1] = 32'hB1B1B1B1;
        mem[4] = 32'hDEADBEEF;
        //          cr cw ca     cd            dr dw da     dd            cg dg st crv drv rd            we ma     md
        v[0]  = mk(0, 0, 32'h0,  32'h0,        0, 0, 32'h0,  32'h0,        0, 0, 0, 0, 0, 32'h0,        0, 32'h0,  32'h0);
        v[1]  = mk(1, 0, 32'h10, 32'h0,        0, 0, 32'h0,  32'h0,        1, 0, 0, 0, 0, 32'h0,        0, 32'h10, 32'h0);
        v[2]  = mk(0, 0, 32'h0,  32'h0,        0, 0, 32'h0,  32'h0,        0, 0, 0, 1, 0, 32'hDEADBEEF, 0, 32'h0,  32'h0);
        v[3]  = mk(0, 0, 32'h0,  32'h0,        1, 1, 32'h20, 32'h12345678, 0, 1, 0, 0, 0, 32'h0,        1, 32'h20, 32'h12345678);
        v[4]  = mk(1, 0, 32'h20, 32'h0,        0, 0, 32'h0,  32'h0,        1, 0, 0, 0, 0, 32'h0,        0, 32'h20, 32'h0);
        v[5]  = mk(0, 0, 32'h0,  32'h0,        0, 0, 32'h0,  32'h0,        0, 0, 0, 1, 0, 32'h12345678, 0, 32'h0,  32'h0);
        v[6]  = mk(1, 0, 32'h0,  32'h0,        0, 0, 32'h0,  32'h0,        1, 0, 0, 0, 0, 32'h0,        0, 32'h0,  32'h0);
        v[7]  = mk(0, 0, 32'h0,  32'h0,        1, 0, 32'h4,  32'h0,        0, 1, 0, 1, 0, 32'hA0A0A0A0, 0, 32'h4,  32'h0);
        v[8]  = mk(0, 0, 32'h0,  32'h0,        0, 0, 32'h0,  32'h0,        0, 0, 0, 0, 1, 32'hB1B1B1B1, 0, 32'h0,  32'h0);
        v[9]  = mk(0, 0, 32'h0,  32'h0,        0, 0, 32'h0,  32'h0,        0, 0, 0, 0, 0, 32'h0,        0, 32'h0,  32'h0);
        for (int i = 10; i < 22; i++) begin
            if (i == 14 || i == 19)
                v[i] = mk(1, 1, 32'h30, 32'h11111111, 1, 1, 32'h34, 32'h22222222, 0, 1, 1, 0, 0, 32'h0, 1, 32'h34, 32'h22222222);
            else
                v[i] = mk(1, 1, 32'h30, 32'h11111111, 1, 1, 32'h34, 32'h22222222, 1, 0, 0, 0, 0, 32'h0, 1, 32'h30, 32'h11111111);
        end
        v[22] = mk(1, 1, 32'h30, 32'h11111111, 0, 1, 32'h34, 32'h22222222, 1, 0, 0, 0, 0, 32'h0, 1, 32'h30, 32'h11111111);
        for (int i = 23; i < 27; i++)
            v[i] = mk(1, 1, 32'h30, 32'h11111111, 1, 1, 32'h34, 32'h22222222, 1, 0, 0, 0, 0, 32'h0, 1, 32'h30, 32'h11111111);
        v[27] = mk(1, 1, 32'h30, 32'h11111111, 1, 1, 32'h34, 32'h22222222, 0, 1, 1, 0, 0, 32'h0, 1, 32'h34, 32'h22222222);
        v[28] = mk(0, 0, 32'h0,  32'h0,        0, 0, 32'h0,  32'h0,        0, 0, 0, 0, 0, 32'h0,        0, 32'h0,  32'h0);

        rst = 1'b0;
        core_req = 1'b1; core_we = 1'b1; core_addr = 32'h8; core_wdata = 32'h55;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'hC; dma_wdata = 32'h66;
        repeat (2) @(negedge clk);
        #1;
        chk_zero(-1);
        @(negedge clk);
        drive(v[0]);
        rst = 1'b1;

        for (int i = 0; i < 29; i++) begin
            @(negedge clk);
            drive(v[i]);
            #1;
            chk("core_gnt", i, 32'(core_gnt), 32'(v[i].e_cg));
            chk("dma_gnt", i, 32'(dma_gnt), 32'(v[i].e_dg));
            chk("core_stall", i, 32'(core_stall), 32'(v[i].e_st));
            chk("core_rvalid", i, 32'(core_rvalid), 32'(v[i].e_crv));
            chk("dma_rvalid", i, 32'(dma_rvalid), 32'(v[i].e_drv));
            chk("mem_we", i, 32'(mem_we), 32'(v[i].e_we));
            chk("mem_addr", i, mem_addr, v[i].e_ma);
            chk("mem_wdata", i, mem_wdata, v[i].e_md);
            if (v[i].e_crv) chk("core_rdata", i, core_rdata, v[i].e_rd);
            if (v[i].e_drv) chk("dma_rdata", i, dma_rdata, v[i].e_rd);
`ifdef DMEM_ARB_PERF_EN
            if (i == 10) begin
                s_c = core_gnt_cnt; s_d = dma_gnt_cnt; s_x = conflict_cnt;
            end
            if (i == 20) begin
                chk("perf_conflict", i, conflict_cnt - s_x, 32'd10);
                chk("perf_core_gnt", i, core_gnt_cnt - s_c, 32'd8);
                chk("perf_dma_gnt", i, dma_gnt_cnt - s_d, 32'd2);
            end
`endif
        end

        @(negedge clk);
        drive(mk(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0));
        #1;
        chk("rst_seq_core_gnt", 100, 32'(core_gnt), 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_zero(101);
`ifdef DMEM_ARB_PERF_EN
        chk("perf_clear", 101, conflict_cnt | core_gnt_cnt | dma_gnt_cnt, 32'd0);
`endif
        @(negedge clk);
        drive(v[0]);
        rst = 1'b1;
        #1;
        chk_zero(102);
        @(negedge clk);
        #1;
        chk_zero(103);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
